vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Consumes the one-in-four pixel-enable strobe from the system clock divider and produces VGA raster timing.
- Outputs: hsync, vsync, active-video flag, current pixel coordinates, and a frame-start pulse.
- Sits between the pixel-enable source and the renderer / colour output stage.
- Everything runs in the clk domain; pixel_en is a clock enable, never a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hsync/vsync while asserted (0 = active-low)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_en  input  1  one-clk strobe, one per pixel period; may be irregular or held high
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- video_on  output  1  high when the current position is in the visible area
- pixel_x  output  CW  current horizontal count
- pixel_y  output  CW  current vertical count
- frame_start  output  1  one-clk pulse when the position moves to (0,0)

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Reset (async, immediate, including mid-frame):
  - h_count=0, v_count=0, started=0.
  - hsync=vsync=~SYNC_ACTIVE, video_on=0, pixel_x=0, pixel_y=0, frame_start=0.
- State and change rules:
  - Internal state is h_count, v_count and the started flag.
  - State changes only on clk edges where pixel_en=1.
  - With pixel_en=0, all outputs hold, except frame_start, which returns to 0.
- First pixel_en after reset:
  - Sets started=1.
  - Counters stay at (0,0).
  - Outputs present position (0,0): video_on=1, syncs inactive.
  - frame_start=1 for that one clk.
- Subsequent pixel_en (started=1):
  - h_count increments.
  - At h_count=H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - At v_count=V_TOTAL-1 together with h_count=H_TOTAL-1, both wrap to 0 and frame_start pulses for one clk.
- Registered outputs, consistent with the new counter values on the same edge (decode from next-state; no combinational decode from the outputs):
  - pixel_x=h_count, pixel_y=v_count (unclamped; counts beyond the visible area are reported as-is).
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FP ≤ h_count < H_ACTIVE+H_FP+H_SYNC (656..751 by default), otherwise inactive.
  - vsync = SYNC_ACTIVE when V_ACTIVE+V_FP ≤ v_count < V_ACTIVE+V_FP+V_SYNC (490..491 by default), otherwise inactive. vsync is line-based: it is asserted for the whole of each sync line.
- Output latency: 1 clk from the pixel_en edge.
- No glitches: every output comes directly from a flop.
- Frame length: exactly H_TOTAL*V_TOTAL pixel_en strobes per frame (420000 by default), independent of gaps between strobes.
- Continuous pixel_en=1: legal; the raster advances every clk.

Test Plan:
- Reset and first strobe:
  - Assert reset, release, wait 10 clk with pixel_en=0 -> syncs high, video_on=0, x=y=0, frame_start=0 throughout.
  - First pixel_en -> video_on=1, (0,0), frame_start=1 for exactly one clk.
- hsync timing:
  - Drive pixel_en 1-in-4 -> hsync goes low on the strobe presenting x=656.
  - hsync returns high at x=752 (96 strobes = 384 clk).
  - video_on falls at x=640.
- Line wrap: at x=799, y=5, the next strobe -> x=0, y=6, video_on=1, no frame_start.
- Vertical timing and frame wrap:
  - vsync is low exactly for y=490..491 (all x).
  - Strobe at (799,524) -> (0,0) with a frame_start pulse.
  - Count 420000 strobes between consecutive frame_start pulses.
- Irregular strobes: random pixel_en gaps of 0–7 clk and held-high bursts -> outputs hold during gaps; the x/y sequence matches the reference counter model; frame length stays 420000.
- Mid-frame reset: assert reset at (300,200) between clk edges -> outputs return to reset values immediately; the next pixel_en presents (0,0) with frame_start.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator driven by a pixel-enable strobe.
//
// The position (h_count, v_count) advances once per pixel_en strobe. All outputs
// are registered and decoded from the next-state position. Their values
// therefore always match the position that the edge has just moved to.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pixel_en     one-clk strobe per pixel period (irregular or held high allowed)
//   hsync        horizontal sync, level SYNC_ACTIVE while asserted
//   vsync        vertical sync, level SYNC_ACTIVE while asserted (whole lines)
//   video_on     high while the current position is inside the visible area
//   pixel_x      current horizontal count (unclamped)
//   pixel_y      current vertical count (unclamped)
//   frame_start  one-clk pulse when the position moves to (0,0)
module vga_sync_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   CW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pixel_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] ONE          = CW'(1);

    logic [CW-1:0] h_count_q, h_count_d;
    logic [CW-1:0] v_count_q, v_count_d;
    logic          started_q, started_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        h_count_d     = h_count_q;
        v_count_d     = v_count_q;
        started_d     = started_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        frame_start_d = 1'b0;

        if (pixel_en) begin
            if (!started_q) begin
                // First strobe after reset presents (0,0) without advancing,
                // so the very first frame is a full frame.
                started_d     = 1'b1;
                h_count_d     = '0;
                v_count_d     = '0;
                frame_start_d = 1'b1;
            end else if (h_count_q == H_LAST) begin
                h_count_d = '0;
                if (v_count_q == V_LAST) begin
                    v_count_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_count_d = v_count_q + ONE;
                end
            end else begin
                h_count_d = h_count_q + ONE;
            end

            video_on_d = (h_count_d < H_ACT_END) && (v_count_d < V_ACT_END);
            hsync_d    = ((h_count_d >= H_SYNC_START) && (h_count_d < H_SYNC_END))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d    = ((v_count_d >= V_SYNC_START) && (v_count_d < V_SYNC_END))
                         ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            started_q     <= 1'b0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            started_q     <= started_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    // The counters are flops and hold the reported position directly.
    assign pixel_x     = h_count_q;
    assign pixel_y     = v_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule
